// File: rtl/database_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between the database IP's bus master and its S00_AXI register file.
interface database_axi_lite_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/database_axi_lite_regs.sv
// AXI4-Lite slave holding four 32-bit R/W registers for the database core, with a one-cycle
// write strobe per register. Write and read paths are independent single-outstanding FSMs.
module database_axi_lite_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  database_axi_lite_regs_if.slave         s00_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_o,
  output logic [3:0]                      wr_pulse_o
);
  localparam int unsigned NumLanes = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] WIdle = 2'd0;
  localparam logic [1:0] WData = 2'd1;
  localparam logic [1:0] WAddr = 2'd2;
  localparam logic [1:0] WResp = 2'd3;
  localparam logic       RIdle = 1'b0;
  localparam logic       RData = 1'b1;

  logic [1:0]                       wstate_q, wstate_d;
  logic                             rstate_q;
  logic [1:0]                       awidx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]    wdata_q;
  logic [NumLanes-1:0]              wstrb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]    rdata_q;
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q;
  logic [3:0]                       wr_pulse_q;

  logic                             aw_hs, w_hs, ar_hs, commit;
  logic [1:0]                       commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]    commit_data;
  logic [NumLanes-1:0]              commit_strb;
  logic                             unused_bits;

  // Outputs are forced idle combinationally while reset is held, so nothing leaks out
  // during the reset cycle itself and READYs come up in the first cycle reset is low.
  assign s00_axi.AWREADY = !ARESET && (wstate_q == WIdle || wstate_q == WAddr);
  assign s00_axi.WREADY  = !ARESET && (wstate_q == WIdle || wstate_q == WData);
  assign s00_axi.BVALID  = !ARESET && (wstate_q == WResp);
  assign s00_axi.BRESP   = 2'b00;
  assign s00_axi.ARREADY = !ARESET && (rstate_q == RIdle);
  assign s00_axi.RVALID  = !ARESET && (rstate_q == RData);
  assign s00_axi.RDATA   = ARESET ? '0 : rdata_q;
  assign s00_axi.RRESP   = 2'b00;
  assign reg_o           = ARESET ? '0 : regs_q;
  assign wr_pulse_o      = ARESET ? '0 : wr_pulse_q;

  assign aw_hs = s00_axi.AWVALID && s00_axi.AWREADY;
  assign w_hs  = s00_axi.WVALID && s00_axi.WREADY;
  assign ar_hs = s00_axi.ARVALID && s00_axi.ARREADY;

  // Whichever half arrived earlier comes from its capture register.
  assign commit_idx  = (wstate_q == WData) ? awidx_q : s00_axi.AWADDR[3:2];
  assign commit_data = (wstate_q == WAddr) ? wdata_q : s00_axi.WDATA;
  assign commit_strb = (wstate_q == WAddr) ? wstrb_q : s00_axi.WSTRB;

  assign unused_bits = ^{s00_axi.AWPROT, s00_axi.ARPROT, s00_axi.AWADDR[1:0],
                         s00_axi.ARADDR[1:0]};

  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    case (wstate_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wstate_d = WResp;
        end else if (aw_hs) begin
          wstate_d = WData;
        end else if (w_hs) begin
          wstate_d = WAddr;
        end
      end
      WData: begin
        if (w_hs) begin
          commit   = 1'b1;
          wstate_d = WResp;
        end
      end
      WAddr: begin
        if (aw_hs) begin
          commit   = 1'b1;
          wstate_d = WResp;
        end
      end
      WResp: begin
        if (s00_axi.BREADY) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q   <= WIdle;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) awidx_q <= s00_axi.AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= s00_axi.WDATA;
        wstrb_q <= s00_axi.WSTRB;
      end
      wr_pulse_q <= commit ? (4'b0001 << commit_idx) : 4'b0000;
      if (commit) begin
        for (int unsigned k = 0; k < NumLanes; k++) begin
          if (commit_strb[k]) regs_q[commit_idx][8*k +: 8] <= commit_data[8*k +: 8];
        end
      end
    end
  end

  // RDATA samples regs_q before any same-edge commit lands, so a colliding read sees old data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q <= RIdle;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rstate_q <= RData;
      rdata_q  <= regs_q[s00_axi.ARADDR[3:2]];
    end else if (rstate_q == RData && s00_axi.RREADY) begin
      rstate_q <= RIdle;
    end
  end
endmodule

// File: tb/tb_database_axi_lite_regs.sv
// Self-checking bench for database_axi_lite_regs: directed scenarios plus randomized
// reads/writes scored against an array model of the four registers.
module tb_database_axi_lite_regs;
  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [127:0] reg_o;
  logic [3:0]   wr_pulse_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [4];

  database_axi_lite_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  database_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s00_axi    (bus),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    model[addr / 4] = (model[addr / 4] & ~mask) | (data & mask);
  endfunction

  // w_lead > 0: W is offered that many cycles before AW; w_lead < 0: AW leads.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_delay);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done  = 0;
    w_done   = 0;
    cyc      = 0;
    bus.AWADDR = addr;
    bus.AWPROT = 3'($urandom);
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.AWVALID = !aw_done && cyc >= aw_start;
      bus.WVALID  = !w_done && cyc >= w_start;
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      tick();
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      if (!(aw_done && w_done)) begin
        check("wr_wait_regs", reg_o, model_flat());
        check("wr_wait_pulse", wr_pulse_o, 4'b0000);
        if (w_done) check("wready_drop", bus.WREADY, 1'b0);
        if (aw_done) check("awready_drop", bus.AWREADY, 1'b0);
      end
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    model_write(addr, data, strb);
    check("wr_regs", reg_o, model_flat());
    check("wr_pulse", wr_pulse_o, 4'b0001 << (addr / 4));
    check("bvalid", bus.BVALID, 1'b1);
    check("bresp", bus.BRESP, 2'b00);
    for (int i = 0; i < 20; i++) begin
      bus.BREADY  = (i >= b_delay);
      bus.AWVALID = !bus.BREADY;
      bus.WVALID  = !bus.BREADY;
      bus.AWADDR  = 4'($urandom);
      bus.WDATA   = $urandom;
      bus.WSTRB   = 4'hF;
      if (!bus.BREADY) begin
        check("b_hold_awready", bus.AWREADY, 1'b0);
        check("b_hold_wready", bus.WREADY, 1'b0);
      end
      tick();
      if (bus.BREADY) break;
      check("b_hold_bvalid", bus.BVALID, 1'b1);
      check("b_hold_pulse", wr_pulse_o, 4'b0000);
      check("b_hold_regs", reg_o, model_flat());
    end
    bus.BREADY  = 1'b0;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    check("b_done_bvalid", bus.BVALID, 1'b0);
    check("b_done_awready", bus.AWREADY, 1'b1);
    check("b_done_wready", bus.WREADY, 1'b1);
    check("b_done_regs", reg_o, model_flat());
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_delay);
    logic [31:0] exp;
    int cyc;
    bus.ARADDR  = addr;
    bus.ARPROT  = 3'($urandom);
    bus.ARVALID = 1'b1;
    cyc = 0;
    while (!bus.ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ar_accept", bus.ARREADY, 1'b1);
    exp = model[addr / 4];
    tick();
    bus.ARVALID = 1'b0;
    check("rvalid", bus.RVALID, 1'b1);
    check("rdata", bus.RDATA, exp);
    check("rresp", bus.RRESP, 2'b00);
    check("r_arready_low", bus.ARREADY, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.RREADY  = (i >= r_delay);
      bus.ARVALID = !bus.RREADY;
      bus.ARADDR  = 4'($urandom);
      tick();
      if (bus.RREADY) break;
      check("r_hold_rvalid", bus.RVALID, 1'b1);
      check("r_hold_rdata", bus.RDATA, exp);
      check("r_hold_arready", bus.ARREADY, 1'b0);
    end
    bus.RREADY  = 1'b0;
    bus.ARVALID = 1'b0;
    check("r_done_rvalid", bus.RVALID, 1'b0);
    check("r_done_arready", bus.ARREADY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] strb;
    for (int i = 0; i < 4; i++) model[i] = '0;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WSTRB  = '0; bus.WVALID  = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    ARESET = 1'b1;

    // Reset held
    tick();
    tick();
    check("rst_awready", bus.AWREADY, 1'b0);
    check("rst_wready", bus.WREADY, 1'b0);
    check("rst_arready", bus.ARREADY, 1'b0);
    check("rst_bvalid", bus.BVALID, 1'b0);
    check("rst_rvalid", bus.RVALID, 1'b0);
    check("rst_rdata", bus.RDATA, 32'h0);
    check("rst_regs", reg_o, 128'h0);
    check("rst_pulse", wr_pulse_o, 4'b0000);
    ARESET = 1'b0;
    #1;
    check("rel_awready", bus.AWREADY, 1'b1);
    check("rel_wready", bus.WREADY, 1'b1);
    check("rel_arready", bus.ARREADY, 1'b1);

    // Aligned writes and read-back
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0);
    check("all_regs_1234", reg_o, {32'd4, 32'd3, 32'd2, 32'd1});

    // Split write, W three cycles ahead of AW
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
    check("split_reg2", reg_o[95:64], 32'hDEADBEEF);

    // Byte strobes
    axi_write(4'h0, 32'h11223344, 4'hF, 0, 0);
    axi_write(4'h0, 32'hAABBCCDD, 4'b0101, 0, 0);
    check("strb_reg0", reg_o[31:0], 32'h11BB33DD);
    axi_write(4'h0, 32'hFFFFFFFF, 4'b0000, 0, 0);
    check("strb0_reg0", reg_o[31:0], 32'h11BB33DD);

    // Backpressure
    axi_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 5);
    axi_read(4'hC, 5);

    // Same-edge read and write of reg1
    axi_write(4'h4, 32'h5, 4'hF, 0, 0);
    bus.ARADDR = 4'h4; bus.ARVALID = 1'b1;
    bus.AWADDR = 4'h4; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h9; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    tick();
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("coll_rdata", bus.RDATA, 32'h5);
    check("coll_reg1", reg_o[63:32], 32'h9);
    check("coll_pulse", wr_pulse_o, 4'b0010);
    model[1] = 32'h9;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    check("coll_bdone", bus.BVALID, 1'b0);
    check("coll_rdone", bus.RVALID, 1'b0);
    axi_read(4'h4, 0);

    // Reset while in W_RESP and R_DATA
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1; bus.WDATA = 32'h1234; bus.WSTRB = 4'hF;
    bus.WVALID = 1'b1; bus.ARADDR = 4'h0; bus.ARVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("pre_rst_bvalid", bus.BVALID, 1'b1);
    check("pre_rst_rvalid", bus.RVALID, 1'b1);
    ARESET = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("mid_rst_bvalid", bus.BVALID, 1'b0);
    check("mid_rst_rvalid", bus.RVALID, 1'b0);
    check("mid_rst_regs", reg_o, model_flat());
    check("mid_rst_pulse", wr_pulse_o, 4'b0000);
    ARESET = 1'b0;
    #1;
    check("post_rst_awready", bus.AWREADY, 1'b1);
    check("post_rst_wready", bus.WREADY, 1'b1);
    check("post_rst_arready", bus.ARREADY, 1'b1);
    tick();
    check("post_rst_bvalid", bus.BVALID, 1'b0);
    check("post_rst_rvalid", bus.RVALID, 1'b0);
    check("post_rst_regs", reg_o, 128'h0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        strb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
        axi_write(4'($urandom), $urandom, strb, int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)));
      end else begin
        axi_read(4'($urandom), int'($urandom_range(0, 3)));
      end
    end
    check("final_regs", reg_o, model_flat());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
